// File: rtl/sync_fifo_fwft_if.sv
// Handshake/data bundle for sync_fifo_fwft: producer/consumer side is master,
// the FIFO itself is slave.
interface sync_fifo_fwft_if #(
  parameter int DEPTH = 256,
  parameter int DWID  = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic            i_clear;
  logic            i_write;
  logic [DWID-1:0] i_din;
  logic            o_full;
  logic            o_almost_full;
  logic            i_read;
  logic [DWID-1:0] o_dout;
  logic            o_empty;
  logic            o_almost_empty;
  logic [CW-1:0]   o_count;
  logic            o_overflow;
  logic            o_underflow;

  modport master (
    output i_clear, i_write, i_din, i_read,
    input  o_full, o_almost_full, o_dout, o_empty, o_almost_empty,
           o_count, o_overflow, o_underflow
  );

  modport slave (
    input  i_clear, i_write, i_din, i_read,
    output o_full, o_almost_full, o_dout, o_empty, o_almost_empty,
           o_count, o_overflow, o_underflow
  );
endinterface

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with selectable standard / first-word-fall-through read,
// threshold flags, occupancy count, sticky error flags and synchronous flush.
module sync_fifo_fwft #(
  parameter int DEPTH    = 256,
  parameter int DWID     = 16,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  sync_fifo_fwft_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DWID-1:0] mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;
  logic [DWID-1:0] dout_q, dout_d;
  logic            full, empty, wr_acc, rd_acc;
  logic [DWID-1:0] head;

  // Explicit wrap so non-power-of-two depths never rely on binary rollover.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign wr_acc = bus.i_write && !full  && !bus.i_clear;
  assign rd_acc = bus.i_read  && !empty && !bus.i_clear;
  assign head   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    dout_d   = dout_q;
    if (bus.i_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
      dout_d   = '0;
    end else begin
      if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_acc) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
        dout_d   = head;
      end
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (bus.i_write && full)  ovf_d = 1'b1;
      if (bus.i_read  && empty) udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      dout_q   <= dout_d;
    end
  end

  // Storage carries no reset; contents are only visible through valid pointers.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= bus.i_din;
  end

  assign bus.o_full         = full;
  assign bus.o_empty        = empty;
  assign bus.o_almost_full  = (count_q >= CW'(AF_LEVEL));
  assign bus.o_almost_empty = (count_q <= CW'(AE_LEVEL));
  assign bus.o_count        = count_q;
  assign bus.o_overflow     = ovf_q;
  assign bus.o_underflow    = udf_q;
  assign bus.o_dout         = (FWFT != 0) ? (empty ? '0 : head) : dout_q;
endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Directed bench: standard-read FIFO (DEPTH 8), FWFT FIFO (DEPTH 4) and a
// non-power-of-two FIFO (DEPTH 6) sharing one clock and reset.
module tb_sync_fifo_fwft;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  sync_fifo_fwft_if #(.DEPTH(8), .DWID(8)) a_if ();
  sync_fifo_fwft_if #(.DEPTH(4), .DWID(8)) b_if ();
  sync_fifo_fwft_if #(.DEPTH(6), .DWID(8)) c_if ();

  sync_fifo_fwft #(.DEPTH(8), .DWID(8), .FWFT(0), .AF_LEVEL(4), .AE_LEVEL(2))
    u_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
  sync_fifo_fwft #(.DEPTH(4), .DWID(8), .FWFT(1), .AF_LEVEL(3), .AE_LEVEL(1))
    u_b (.clk(clk), .rst_n(rst_n), .bus(b_if));
  sync_fifo_fwft #(.DEPTH(6), .DWID(8), .FWFT(0), .AF_LEVEL(5), .AE_LEVEL(1))
    u_c (.clk(clk), .rst_n(rst_n), .bus(c_if));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int mq[$];
    int wi;
    int t;
    int exp_v;
    bit do_w, do_r;

    {a_if.i_clear, a_if.i_write, a_if.i_read, a_if.i_din} = '0;
    {b_if.i_clear, b_if.i_write, b_if.i_read, b_if.i_din} = '0;
    {c_if.i_clear, c_if.i_write, c_if.i_read, c_if.i_din} = '0;

    // reset
    #2 rst_n = 1'b0;
    #1;
    chk("rst_empty", a_if.o_empty, 1);
    chk("rst_ae",    a_if.o_almost_empty, 1);
    chk("rst_full",  a_if.o_full, 0);
    chk("rst_af",    a_if.o_almost_full, 0);
    chk("rst_count", a_if.o_count, 0);
    chk("rst_ovf",   a_if.o_overflow, 0);
    chk("rst_udf",   a_if.o_underflow, 0);
    chk("rst_dout",  a_if.o_dout, 0);
    chk("rst_b_dout", b_if.o_dout, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // A: fill 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      a_if.i_write = 1'b1;
      a_if.i_din   = 8'(i);
      tick();
      chk("fill_count", a_if.o_count, i);
      chk("fill_af",    a_if.o_almost_full, (i >= 4) ? 1 : 0);
      chk("fill_ae",    a_if.o_almost_empty, (i <= 2) ? 1 : 0);
    end
    chk("fill_full", a_if.o_full, 1);
    a_if.i_din = 8'h09;
    tick();
    a_if.i_write = 1'b0;
    chk("ovf_count", a_if.o_count, 8);
    chk("ovf_flag",  a_if.o_overflow, 1);

    // A: drain
    for (int i = 1; i <= 8; i++) begin
      a_if.i_read = 1'b1;
      tick();
      chk("drain_dout",  a_if.o_dout, i);
      chk("drain_count", a_if.o_count, 8 - i);
    end
    chk("drain_empty", a_if.o_empty, 1);
    tick();
    a_if.i_read = 1'b0;
    chk("udf_flag", a_if.o_underflow, 1);
    chk("udf_dout", a_if.o_dout, 8'h08);
    chk("udf_count", a_if.o_count, 0);

    // B: FWFT
    b_if.i_write = 1'b1;
    b_if.i_din   = 8'hA5;
    tick();
    b_if.i_write = 1'b0;
    chk("fwft_empty", b_if.o_empty, 0);
    chk("fwft_dout",  b_if.o_dout, 8'hA5);
    tick();
    chk("fwft_hold",  b_if.o_dout, 8'hA5);
    b_if.i_read = 1'b1;
    tick();
    b_if.i_read = 1'b0;
    chk("fwft_rd_dout",  b_if.o_dout, 0);
    chk("fwft_rd_empty", b_if.o_empty, 1);
    b_if.i_write = 1'b1;
    b_if.i_din   = 8'h3C;
    tick();
    b_if.i_din   = 8'hC3;
    tick();
    b_if.i_write = 1'b0;
    chk("fwft_head1", b_if.o_dout, 8'h3C);
    b_if.i_read = 1'b1;
    tick();
    b_if.i_read = 1'b0;
    chk("fwft_head2", b_if.o_dout, 8'hC3);
    chk("fwft_cnt",   b_if.o_count, 1);

    // C: simultaneous read/write at count 3
    c_if.i_write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      c_if.i_din = 8'(8'h10 + i);
      tick();
    end
    c_if.i_read = 1'b1;
    c_if.i_din  = 8'h13;
    tick();
    chk("rw3_count", c_if.o_count, 3);
    chk("rw3_dout",  c_if.o_dout, 8'h10);
    c_if.i_din  = 8'h14;
    tick();
    chk("rw3_count2", c_if.o_count, 3);
    chk("rw3_dout2",  c_if.o_dout, 8'h11);
    c_if.i_read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      c_if.i_din = 8'(8'h15 + i);
      tick();
    end
    chk("c_full", c_if.o_full, 1);
    chk("c_af",   c_if.o_almost_full, 1);
    // full: read accepted, write rejected
    c_if.i_read = 1'b1;
    c_if.i_din  = 8'h18;
    tick();
    c_if.i_write = 1'b0;
    chk("rwf_count", c_if.o_count, 5);
    chk("rwf_ovf",   c_if.o_overflow, 1);
    chk("rwf_dout",  c_if.o_dout, 8'h12);
    chk("rwf_full",  c_if.o_full, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("c_drain", c_if.o_dout, 8'h13 + i);
    end
    chk("c_drain_cnt", c_if.o_count, 0);
    // empty: write accepted, read rejected
    c_if.i_write = 1'b1;
    c_if.i_din   = 8'h20;
    tick();
    c_if.i_write = 1'b0;
    chk("rwe_count", c_if.o_count, 1);
    chk("rwe_udf",   c_if.o_underflow, 1);
    chk("rwe_dout",  c_if.o_dout, 8'h17);
    tick();
    c_if.i_read = 1'b0;
    chk("rwe_rd_dout", c_if.o_dout, 8'h20);
    chk("rwe_rd_cnt",  c_if.o_count, 0);

    // C: wrap stream of 20 words with interleaved reads
    wi = 0;
    t  = 0;
    while ((wi < 20 || mq.size() > 0) && t < 80) begin
      do_w = (wi < 20) && (t % 4 != 3);
      do_r = (mq.size() > 0) && (mq.size() >= 3 || wi >= 20);
      c_if.i_write = do_w;
      c_if.i_din   = 8'(8'h30 + wi);
      c_if.i_read  = do_r;
      exp_v = 0;
      if (do_r) exp_v = mq.pop_front();
      if (do_w) begin
        mq.push_back(8'h30 + wi);
        wi++;
      end
      tick();
      if (do_r) chk("wrap_dout", c_if.o_dout, exp_v);
      chk("wrap_count", c_if.o_count, mq.size());
      t++;
    end
    c_if.i_write = 1'b0;
    c_if.i_read  = 1'b0;
    chk("wrap_empty", c_if.o_empty, 1);

    // C: clear with concurrent write at count 4
    c_if.i_write = 1'b1;
    for (int i = 0; i < 4; i++) begin
      c_if.i_din = 8'(8'h40 + i);
      tick();
    end
    chk("pre_clr_cnt", c_if.o_count, 4);
    chk("pre_clr_ovf", c_if.o_overflow, 1);
    c_if.i_clear = 1'b1;
    c_if.i_din   = 8'h44;
    tick();
    c_if.i_clear = 1'b0;
    c_if.i_write = 1'b0;
    chk("clr_count", c_if.o_count, 0);
    chk("clr_empty", c_if.o_empty, 1);
    chk("clr_ovf",   c_if.o_overflow, 0);
    chk("clr_udf",   c_if.o_underflow, 0);
    chk("clr_dout",  c_if.o_dout, 0);
    chk("clr_af",    c_if.o_almost_full, 0);

    // A: asynchronous reset mid-cycle
    a_if.i_write = 1'b1;
    a_if.i_din   = 8'h55;
    tick();
    a_if.i_write = 1'b0;
    chk("pre_ar_cnt", a_if.o_count, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_count", a_if.o_count, 0);
    chk("ar_empty", a_if.o_empty, 1);
    chk("ar_udf",   a_if.o_underflow, 0);
    chk("ar_ovf",   a_if.o_overflow, 0);
    chk("ar_dout",  a_if.o_dout, 0);
    chk("ar_b_empty", b_if.o_empty, 1);
    #1 rst_n = 1'b1;
    a_if.i_write = 1'b1;
    a_if.i_din   = 8'h77;
    tick();
    a_if.i_write = 1'b0;
    a_if.i_read  = 1'b1;
    tick();
    a_if.i_read  = 1'b0;
    chk("post_ar_dout", a_if.o_dout, 8'h77);
    chk("post_ar_cnt",  a_if.o_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
